// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction memory boot loader and CPU/programming-port access arbiter
module imem_boot_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       cpu_fetch_addr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              fetch_fault,
    output logic              cpu_stall,
    output logic              cpu_restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              load_busy,
    output logic              load_done
);

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        COMMIT,
        RESTART
    } state_t;

    // Word counter is one bit wider than the address so a full image is visible as DEPTH.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] WORD_INC  = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [31:0]       asm_word;
    logic              load_done_r;
    logic              byte_accept;

    assign byte_accept = byte_valid & byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        byte_ready  = 1'b0;
        cpu_stall   = 1'b1;
        cpu_restart = 1'b0;
        mem_we      = 1'b0;
        load_busy   = 1'b0;
        fetch_fault = 1'b0;
        mem_raddr   = word_cnt[ADDR_W-1:0];
        unique case (state)
            RUN: begin
                cpu_stall   = 1'b0;
                mem_raddr   = cpu_fetch_addr[ADDR_W+1:2];
                fetch_fault = (|cpu_fetch_addr[1:0]) | (|cpu_fetch_addr[31:ADDR_W+2]);
                if (load_req) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
                if (byte_valid && byte_cnt == 2'd3) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                mem_we     = 1'b1;
                load_busy  = 1'b1;
                state_next = (word_cnt == LAST_WORD) ? RESTART : LOAD;
            end
            RESTART: begin
                cpu_restart = 1'b1;
                state_next  = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt    <= 2'd0;
            word_cnt    <= '0;
            asm_word    <= 32'd0;
            load_done_r <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (load_req) begin
                        byte_cnt    <= 2'd0;
                        word_cnt    <= '0;
                        load_done_r <= 1'b0;
                    end
                end
                LOAD: begin
                    // Big-endian packing: the first byte of a word ends up in bits 31:24.
                    if (byte_accept) begin
                        asm_word <= {asm_word[23:0], byte_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                COMMIT: begin
                    word_cnt <= word_cnt + WORD_INC;
                end
                RESTART: begin
                    load_done_r <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_waddr = word_cnt[ADDR_W-1:0];
    assign mem_wdata = asm_word;
    assign load_done = load_done_r;

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-load controller and access arbiter for the single-cycle MIPS core's instruction memory. It shares the instruction memory between the CPU fetch path and a byte-serial programming port, such as the board UART receiver. While a load runs, it stalls the CPU, packs incoming bytes into 32-bit big-endian words and writes them sequentially from word 0. When the load finishes, it pulses a CPU restart so execution resumes at PC 0 with the new program.

## Interface
- DEPTH, 16, instruction memory depth in words
- ADDR_W, 4, word-address width; DEPTH = 2**ADDR_W

- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- load_req  in  1  one-cycle request to start a program load; honoured only in RUN
- byte_valid  in  1  programming byte present
- byte_data  in  8  programming byte
- byte_ready  out  1  controller accepts byte this cycle
- cpu_fetch_addr  in  32  CPU PC (byte address)
- mem_raddr  out  ADDR_W  word read address to instruction memory
- fetch_fault  out  1  fetch address misaligned or beyond DEPTH words
- cpu_stall  out  1  CPU must hold PC and suppress all writes
- cpu_restart  out  1  one-cycle pulse: CPU resets PC to 0
- mem_we  out  1  instruction memory write enable
- mem_waddr  out  ADDR_W  write word address
- mem_wdata  out  32  write data
- load_busy  out  1  load in progress (LOAD or COMMIT)
- load_done  out  1  sticky; set when a full load completes, cleared by next load_req

## Operation
- States: RUN, LOAD, COMMIT, RESTART.
- RUN:
  - byte_ready=0, cpu_stall=0.
  - mem_raddr = cpu_fetch_addr[ADDR_W+1:2], combinational.
  - fetch_fault = (cpu_fetch_addr[1:0]!=0) | (cpu_fetch_addr[31:ADDR_W+2]!=0), combinational, RUN only.
  - load_req=1 → LOAD; clears byte counter, word counter and load_done.
- LOAD:
  - byte_ready=1, cpu_stall=1, fetch_fault=0.
  - Each accepted byte (byte_valid&byte_ready at the edge) shifts into a 32-bit assembly register, first byte → bits 31:24.
  - 2-bit byte counter wraps 3→0.
  - When the 4th byte of a word is accepted → COMMIT.
- COMMIT:
  - byte_ready=0.
  - mem_we=1 for exactly one cycle, with mem_waddr=word counter and mem_wdata=assembled word.
  - Word counter then increments.
  - If the word just written was DEPTH-1 → RESTART, else → LOAD.
- RESTART:
  - cpu_restart=1 and cpu_stall=1 for one cycle; load_done set.
  - Next state is RUN.
- load_req outside RUN is ignored; a load cannot be re-triggered mid-load.
- Word counter is ADDR_W+1 bits wide so that reaching DEPTH is detectable without wrap-around; the write address uses its low ADDR_W bits.
- mem_raddr while stalled = mem_waddr; memory read data is don't-care.

## Timing
- Reset values: RUN, all counters 0, assembly register 0, byte_ready=0, cpu_stall=0, cpu_restart=0, mem_we=0, mem_waddr=0, mem_wdata=0, load_busy=0, load_done=0.
- reset dominates every other input in the same cycle.
- Reset mid-load aborts to RUN with no restart pulse. Words already written stay in memory; the partial word is discarded.
- load_req at cycle n → state LOAD at n+1, byte_ready=1 from n+1.
- Fourth byte accepted at edge k → mem_we high during cycle k+1, byte_ready low in that cycle. A byte_valid held across COMMIT is accepted at edge k+2.
- Minimum load time = 5·DEPTH cycles + 1 RESTART cycle.
- Gaps in byte_valid only extend LOAD; no timeout exists.
- cpu_restart and cpu_stall are registered state decodes with no combinational path from the byte inputs. mem_raddr and fetch_fault are combinational from cpu_fetch_addr.

## Test plan
- Reset then RUN fetch: cpu_fetch_addr=0x14 → mem_raddr=5, fetch_fault=0, cpu_stall=0. Address 0x16 → fetch_fault=1. Address 0x40 (DEPTH=16) → fetch_fault=1.
- Full load:
  - Pulse load_req, then stream 64 bytes back-to-back, word i = {8'hA0+i, 8'h11, 8'h22, 8'h33}.
  - Required: 16 single-cycle mem_we pulses at addresses 0..15 with matching data.
  - byte_ready low in each COMMIT cycle.
  - One cpu_restart pulse; load_done=1; RUN after 81 cycles.
- Gappy source: byte_valid toggling every other cycle → identical memory writes; cpu_stall held high throughout.
- load_req during LOAD at word 3 → ignored; the word sequence continues uninterrupted to 15.
- Reset after 2 bytes of word 7 → RUN next cycle, no cpu_restart, no write to address 7. A new load restarts at address 0 with the byte counter at 0.
- Simultaneous load_req and reset → RUN, load_done=0, byte_ready=0.
